gpu_vram_arbiter: RTL and testbench

Shares the single-port video RAM between two requesters: the display line prefetcher and the CPU bus port. The prefetcher is driven by the 1920x1080 timing generator. On each line-start pulse the block fetches one full line of pixel words into a double-banked line buffer, while the scanout side reads the other bank. CPU reads and writes are served in the gaps, with optional guaranteed slots during a fetch.

---
 rtl/gpu_vram_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_gpu_vram_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_vram_arbiter.sv
// gpu_vram_arbiter: shares single-port VRAM between the display line
// prefetcher and the CPU bus port. Fetched words land in a double-banked
// line buffer; CPU transactions fill the gaps between fetches.
// Optional feature macro: VRAM_ARB_CPU_SLOT_EN (guaranteed CPU slot every
// CPU_SLOT fetched words while a line fetch is in progress).
module gpu_vram_arbiter #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LINE_WORDS = 240,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned CPU_SLOT   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_line_start,
  input  logic [10:0]       i_line_y,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_lb_we,
  output logic [8:0]        o_lb_addr,
  output logic [DATA_W-1:0] o_lb_wdata,
  output logic              o_lb_bank,
  output logic              o_underrun
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned LB_W  = CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CPU, S_GAP} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] base, base_nxt;
  logic [CNT_W-1:0]  wcnt, wcnt_nxt;
  logic              pend, pend_nxt;
  logic              stale, stale_nxt;
  logic              bank_nxt;
  logic [LB_W-1:0]   fetch_lb_addr, fetch_lb_addr_nxt;
  logic              fetch_ack, cpu_done, cpu_ok, slot_due, issue;

  logic              cpu_ack_nxt, mem_req_nxt, mem_we_nxt, lb_we_nxt, underrun_nxt;
  logic [DATA_W-1:0] cpu_rdata_nxt, mem_wdata_nxt, lb_wdata_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [LB_W-1:0]   lb_addr_nxt;

  assign fetch_ack = (state == S_FETCH) && i_mem_ack;
  assign cpu_done  = (state == S_CPU) && i_mem_ack;
  // The GAP after a CPU transaction still sees that request high; never re-grant it.
  assign cpu_ok    = i_cpu_req && !o_cpu_ack;
  assign issue     = (state == S_IDLE) || (state == S_GAP);

  // Fetch bookkeeping: line start restarts the line; an in-flight word of an
  // abandoned line (stale) completes without advancing the new line's counter.
  always_comb begin
    bank_nxt  = o_lb_bank;
    base_nxt  = base;
    wcnt_nxt  = wcnt;
    pend_nxt  = pend;
    stale_nxt = stale;
    if (i_line_start) begin
      bank_nxt  = ~o_lb_bank;
      base_nxt  = ADDR_W'(BASE_ADDR + 32'(i_line_y) * LINE_WORDS);
      wcnt_nxt  = '0;
      pend_nxt  = 1'b1;
      stale_nxt = (state == S_FETCH) && !i_mem_ack;
    end else if (fetch_ack) begin
      stale_nxt = 1'b0;
      if (!stale) begin
        if (wcnt == LAST_WORD) begin
          wcnt_nxt = '0;
          pend_nxt = 1'b0;
        end else begin
          wcnt_nxt = wcnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef VRAM_ARB_CPU_SLOT_EN
  logic [CNT_W-1:0] slot_cnt;
  logic             slot_due_q;

  // Open one CPU slot after every CPU_SLOT non-stale fetch acks of the current line.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot_cnt   <= '0;
      slot_due_q <= 1'b0;
    end else if (i_line_start || !pend_nxt) begin
      slot_cnt   <= '0;
      slot_due_q <= 1'b0;
    end else begin
      if (fetch_ack && !stale) begin
        if (slot_cnt == CNT_W'(CPU_SLOT - 1)) begin
          slot_cnt   <= '0;
          slot_due_q <= 1'b1;
        end else begin
          slot_cnt <= slot_cnt + CNT_W'(1);
        end
      end
      if ((state == S_GAP) && (state_nxt == S_CPU)) slot_due_q <= 1'b0;
    end
  end

  assign slot_due = slot_due_q;
`else
  logic unused_cpu_slot;
  assign unused_cpu_slot = ^CPU_SLOT;
  assign slot_due        = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state: fetch beats CPU unless a CPU slot is due; every ack is followed by GAP.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pend_nxt)       state_nxt = S_FETCH;
        else if (i_cpu_req) state_nxt = S_CPU;
      end
      S_FETCH, S_CPU: begin
        if (i_mem_ack) state_nxt = S_GAP;
      end
      S_GAP: begin
        if (pend_nxt)    state_nxt = (slot_due && cpu_ok) ? S_CPU : S_FETCH;
        else if (cpu_ok) state_nxt = S_CPU;
        else             state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output next values: launch a request on entry to FETCH/CPU, hold it until ack.
  always_comb begin
    mem_req_nxt       = (state_nxt == S_FETCH) || (state_nxt == S_CPU);
    mem_we_nxt        = o_mem_we;
    mem_addr_nxt      = o_mem_addr;
    mem_wdata_nxt     = o_mem_wdata;
    fetch_lb_addr_nxt = fetch_lb_addr;
    lb_we_nxt         = fetch_ack;
    lb_addr_nxt       = o_lb_addr;
    lb_wdata_nxt      = o_lb_wdata;
    cpu_ack_nxt       = cpu_done;
    cpu_rdata_nxt     = o_cpu_rdata;
    underrun_nxt      = i_line_start && pend;
    if (issue && (state_nxt == S_FETCH)) begin
      mem_we_nxt        = 1'b0;
      mem_addr_nxt      = base_nxt + ADDR_W'(wcnt_nxt);
      mem_wdata_nxt     = '0;
      fetch_lb_addr_nxt = {bank_nxt, wcnt_nxt};
    end
    if (issue && (state_nxt == S_CPU)) begin
      mem_we_nxt    = i_cpu_we;
      mem_addr_nxt  = i_cpu_addr;
      mem_wdata_nxt = i_cpu_wdata;
    end
    if (fetch_ack) begin
      lb_addr_nxt  = fetch_lb_addr;
      lb_wdata_nxt = i_mem_rdata;
    end
    if (cpu_done && !o_mem_we) cpu_rdata_nxt = i_mem_rdata;
  end

  // Registered outputs and fetch context.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      base          <= '0;
      wcnt          <= '0;
      pend          <= 1'b0;
      stale         <= 1'b0;
      fetch_lb_addr <= '0;
      o_lb_bank     <= 1'b0;
      o_mem_req     <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_lb_we       <= 1'b0;
      o_lb_addr     <= '0;
      o_lb_wdata    <= '0;
      o_cpu_ack     <= 1'b0;
      o_cpu_rdata   <= '0;
      o_underrun    <= 1'b0;
    end else begin
      base          <= base_nxt;
      wcnt          <= wcnt_nxt;
      pend          <= pend_nxt;
      stale         <= stale_nxt;
      fetch_lb_addr <= fetch_lb_addr_nxt;
      o_lb_bank     <= bank_nxt;
      o_mem_req     <= mem_req_nxt;
      o_mem_we      <= mem_we_nxt;
      o_mem_addr    <= mem_addr_nxt;
      o_mem_wdata   <= mem_wdata_nxt;
      o_lb_we       <= lb_we_nxt;
      o_lb_addr     <= lb_addr_nxt;
      o_lb_wdata    <= lb_wdata_nxt;
      o_cpu_ack     <= cpu_ack_nxt;
      o_cpu_rdata   <= cpu_rdata_nxt;
      o_underrun    <= underrun_nxt;
    end
  end

endmodule

// File: tb/tb_gpu_vram_arbiter.sv
// Directed bench for gpu_vram_arbiter with a VRAM model of configurable ack latency.
module tb_gpu_vram_arbiter;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 16;
  localparam logic [ADDR_W-1:0] CPU_A = 20'h0F0F0;

  logic              clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_line_start = 1'b0;
  logic [10:0]       i_line_y = '0;
  logic              i_cpu_req = 1'b0;
  logic              i_cpu_we = 1'b0;
  logic [ADDR_W-1:0] i_cpu_addr = '0;
  logic [DATA_W-1:0] i_cpu_wdata = '0;
  logic              o_cpu_ack;
  logic [DATA_W-1:0] o_cpu_rdata;
  logic              o_mem_req, o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              i_mem_ack;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              o_lb_we;
  logic [8:0]        o_lb_addr;
  logic [DATA_W-1:0] o_lb_wdata;
  logic              o_lb_bank, o_underrun;

  int total = 0;
  int bad = 0;

  // VRAM model: background pattern plus one writable word.
  int                lat = 1;
  int                wait_cnt = 0;
  logic              force_ack = 1'b0;
  logic              st_vld = 1'b0;
  logic [ADDR_W-1:0] st_addr = '0;
  logic [DATA_W-1:0] st_val = '0;

  int   cpu_at;
  logic cpu_ack_seen;

  gpu_vram_arbiter dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_line_start(i_line_start), .i_line_y(i_line_y),
    .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we),
    .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_ack(o_cpu_ack), .o_cpu_rdata(o_cpu_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_lb_we(o_lb_we), .o_lb_addr(o_lb_addr), .o_lb_wdata(o_lb_wdata),
    .o_lb_bank(o_lb_bank), .o_underrun(o_underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  assign i_mem_ack   = force_ack || (o_mem_req && (wait_cnt == lat - 1));
  assign i_mem_rdata = (st_vld && (o_mem_addr == st_addr)) ? st_val : pat(o_mem_addr);

  always @(posedge clk) begin
    if (!o_mem_req || i_mem_ack) wait_cnt <= 0;
    else                         wait_cnt <= wait_cnt + 1;
    if (o_mem_req && i_mem_ack && o_mem_we) begin
      st_vld  <= 1'b1;
      st_addr <= o_mem_addr;
      st_val  <= o_mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Follow a zero-wait line fetch: cycle 1 is the first sample after line start.
  task automatic watch(input int base, input logic bank, input int stop_n,
                       input int tail, input int exp_done);
    int n = 0;
    int cyc = 0;
    int last = 0;
    int ur = 0;
    while ((n < stop_n || cyc < last + tail) && cyc < 3000) begin
      step();
      cyc++;
      i_line_start = 1'b0;
      if (cyc == 1)
        check("first_req", {o_mem_req, o_mem_addr}, {1'b1, ADDR_W'(base)});
      if (o_lb_we) begin
        check("lb_word", {o_lb_addr, o_lb_wdata},
              {bank, 8'(n), pat(ADDR_W'(base + n))});
        n++;
        last = cyc;
      end
      if (o_underrun) ur++;
      if (o_mem_req && (o_mem_addr == CPU_A) && (cpu_at < 0)) cpu_at = n;
      if (o_cpu_ack) begin
        cpu_ack_seen = 1'b1;
        check("slot_rdata", o_cpu_rdata, pat(CPU_A));
        i_cpu_req = 1'b0;
      end
    end
    check("words", n, stop_n);
    if (exp_done >= 0) check("done_cyc", last, exp_done);
    check("no_underrun", ur, 0);
  endtask

  initial begin
    cpu_at = -1;
    cpu_ack_seen = 1'b0;

    // Reset values
    repeat (3) step();
    check("rst_ctrl", {o_cpu_ack, o_mem_req, o_mem_we, o_lb_we, o_lb_bank, o_underrun}, 0);
    check("rst_data", {o_cpu_rdata, o_mem_addr, o_mem_wdata}, 0);
    check("rst_lb", {o_lb_addr, o_lb_wdata}, 0);
    i_rst = 1'b0;
    step();
    check("idle_req", o_mem_req, 0);

    // Full line y=2 into bank 1: addresses 480..719, done at cycle 480
    i_line_start = 1'b1;
    i_line_y = 11'd2;
    watch(480, 1'b1, 240, 2, 480);
    check("bank_after_line", o_lb_bank, 1);

    // CPU write then read on an idle arbiter
    i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 20'h00123; i_cpu_wdata = 16'hBEEF;
    step();
    check("wr_issue", {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata}, {1'b1, 1'b1, 20'h00123, 16'hBEEF});
    check("wr_ack_early", o_cpu_ack, 0);
    step();
    check("wr_ack", o_cpu_ack, 1);
    i_cpu_req = 1'b0;
    step();
    check("wr_after", {o_cpu_ack, o_mem_req}, 0);
    i_cpu_req = 1'b1; i_cpu_we = 1'b0;
    step();
    check("rd_issue", {o_mem_req, o_mem_we, o_mem_addr}, {1'b1, 1'b0, 20'h00123});
    step();
    check("rd_ack", {o_cpu_ack, o_cpu_rdata}, {1'b1, 16'hBEEF});
    i_cpu_req = 1'b0;
    step();
    check("rd_hold", {o_cpu_ack, o_cpu_rdata}, {1'b0, 16'hBEEF});

    // CPU read held during a fetch of line y=3 (bank 0)
    i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = CPU_A;
    i_line_start = 1'b1;
    i_line_y = 11'd3;
    cpu_at = -1;
    cpu_ack_seen = 1'b0;
`ifdef VRAM_ARB_CPU_SLOT_EN
    watch(720, 1'b0, 240, 6, 482);
    check("cpu_slot_word", cpu_at, 16);
`else
    watch(720, 1'b0, 240, 6, 480);
    check("cpu_slot_word", cpu_at, 240);
`endif
    check("cpu_slot_ack", cpu_ack_seen, 1);
    i_cpu_req = 1'b0;

    // Second line start while word 100 is in flight
    i_line_start = 1'b1;
    i_line_y = 11'd5;
    watch(1200, 1'b1, 100, 0, -1);
    step();
    check("ur_inflight", {o_mem_req, o_mem_addr}, {1'b1, 20'd1300});
    i_line_start = 1'b1;
    i_line_y = 11'd7;
    step();
    i_line_start = 1'b0;
    check("ur_pulse", o_underrun, 1);
    check("ur_old_word", {o_lb_we, o_lb_addr, o_lb_wdata}, {1'b1, 1'b1, 8'd100, pat(20'd1300)});
    check("ur_bank", {o_lb_bank, o_mem_req}, 0);
    watch(1680, 1'b0, 240, 2, 480);

    // 3-cycle latency: request stable for 3 cycles, then one GAP
    lat = 3;
    i_line_start = 1'b1;
    i_line_y = 11'd1;
    for (int c = 1; c <= 3; c++) begin
      step();
      i_line_start = 1'b0;
      check("lat_hold", {o_mem_req, o_mem_addr}, {1'b1, 20'd240});
    end
    step();
    check("lat_gap", {o_mem_req, o_lb_we, o_lb_addr, o_lb_wdata}, {1'b0, 1'b1, 1'b1, 8'd0, pat(20'd240)});
    step();
    check("lat_next", {o_mem_req, o_mem_addr}, {1'b1, 20'd241});

    // Reset while the request waits for its ack; the late ack is ignored
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("mid_rst_ctrl", {o_cpu_ack, o_mem_req, o_mem_we, o_lb_we, o_lb_bank, o_underrun}, 0);
    check("mid_rst_data", {o_cpu_rdata, o_mem_addr, o_mem_wdata}, 0);
    check("mid_rst_lb", {o_lb_addr, o_lb_wdata}, 0);
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    check("late_ack_1", {o_lb_we, o_cpu_ack, o_mem_req}, 0);
    step();
    check("late_ack_2", {o_lb_we, o_cpu_ack, o_mem_req}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
